// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queues 6809 byte writes and drains them one at a time to the UART data port.
// Latency: push at edge k -> pop at k+1 -> o_uart_data_ce high from k+2 for STROBE_CYCLES clocks.
// Backpressure: a write to a full queue is dropped and flagged; the drain is paced by UART busy rise/fall.
// Optional IRQ support is built only when TXFIFO_IRQ_EN is defined; otherwise o_IRQ is tied high.

// tx_fifo: generic circular byte queue with occupancy count and a combinational head.
// Latency: a pushed entry is visible in count and head one clock after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [W-1:0]      push_dat,
  input  logic              pop,
  output logic [W-1:0]      head,
  output logic [ADDR_W:0]   count
);
  localparam int CNT_W = ADDR_W + 1;

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int BUSY_TIMEOUT  = 16383
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_RW,
  input  logic              i_fifo_data_ce,
  input  logic              i_fifo_status_ce,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_status,
  output logic [ADDR_W:0]   o_count,
  output logic [7:0]        o_uart_data,
  output logic              o_uart_data_ce,
  output logic              o_uart_rw,
  input  logic              i_uart_busy,
  input  logic              i_irq_enable,
  output logic              o_IRQ
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [3:0]        stb_cnt;
  logic [13:0]       to_cnt;
  logic              wr, wr_d, push_req, push, full, ovf_set;
  logic              rd, rd_d, rd_fall;
  logic              pop, to_fire;
  logic              ovf, to_flag, ovf_nxt, to_nxt;
  logic [7:0]        head;
  logic [ADDR_W:0]   count_nxt;

  // Bus decode: the CE is a level held for the whole access, so only its first clock pushes.
  assign wr       = !i_RW && i_fifo_data_ce;
  assign push_req = wr && !wr_d;
  assign full     = (o_count == CNT_W'(DEPTH));
  assign push     = push_req && !full;
  assign ovf_set  = push_req && full;

  // Sticky bits clear when the CPU's status read ends, so it sees them first.
  assign rd      = i_RW && i_fifo_status_ce;
  assign rd_fall = rd_d && !rd;

  assign pop       = (state == IDLE) && (o_count != '0);
  assign to_fire   = (state == WAIT_BUSY) && !i_uart_busy && (to_cnt == 14'(BUSY_TIMEOUT - 1));
  assign count_nxt = o_count + CNT_W'(push) - CNT_W'(pop);
  // A new event in the same clock as the clear wins, since the CPU has not seen it yet.
  assign ovf_nxt   = ovf_set | (ovf & !rd_fall);
  assign to_nxt    = to_fire | (to_flag & !rd_fall);

  tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(8)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (i_data),
    .pop      (pop),
    .head     (head),
    .count    (o_count)
  );

  // Edge-detect history for the bus chip enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_d <= 1'b0;
      rd_d <= 1'b0;
    end else begin
      wr_d <= wr;
      rd_d <= rd;
    end
  end

  // Status register built from next-state values so it tracks o_count on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf      <= 1'b0;
      to_flag  <= 1'b0;
      o_status <= 8'h01;
    end else begin
      ovf      <= ovf_nxt;
      to_flag  <= to_nxt;
      o_status <= {4'b0000, to_nxt, ovf_nxt,
                   count_nxt == CNT_W'(DEPTH), count_nxt == '0};
    end
  end

  // Drain FSM: pop, strobe the UART, then wait for its busy flag to rise and fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      stb_cnt        <= '0;
      to_cnt         <= '0;
      o_uart_data    <= 8'h00;
      o_uart_data_ce <= 1'b0;
      o_uart_rw      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            o_uart_data <= head;
            stb_cnt     <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (stb_cnt == 4'(STROBE_CYCLES)) begin
            o_uart_data_ce <= 1'b0;
            o_uart_rw      <= 1'b1;
            to_cnt         <= '0;
            state          <= WAIT_BUSY;
          end else begin
            o_uart_data_ce <= 1'b1;
            o_uart_rw      <= 1'b0;
            stb_cnt        <= stb_cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          // A UART that never goes busy lost the byte; give up and move on.
          if (i_uart_busy)  state  <= WAIT_DONE;
          else if (to_fire) state  <= IDLE;
          else              to_cnt <= to_cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!i_uart_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TXFIFO_IRQ_EN
  // Interrupt asks for more data once at most half full, or reports a dropped byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_IRQ <= 1'b1;
    else        o_IRQ <= !(i_irq_enable && ((o_count <= CNT_W'(DEPTH / 2)) || ovf));
  end
`else
  // Without IRQ support the enable has no effect and the line stays deasserted.
  logic irq_enable_unused;
  assign irq_enable_unused = i_irq_enable;
  assign o_IRQ = 1'b1;
`endif
endmodule
